// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline.
//   - Detects load-use hazards and, without forwarding, all RAW hazards
//     against the EXE and MEM stages.
//   - Turns a taken branch into an IF/ID flush plus an ID/EX bubble.
//   - Freezes the whole pipeline while an SRAM access is outstanding.
//   - Latches a sticky error when the SRAM never answers.
//
// Configuration macro: FORWARDING_EN
//   defined   : a forwarding unit exists, so only load-use hazards stall.
//   undefined : any in-flight writer of a source register stalls.
//
// Parameters
//   MEM_TIMEOUT : MEM_WAIT cycles after which an access is declared hung
//   CNT_W       : width of the stall-cycle counter
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   id_valid, src1, src2, two_src  ID-stage instruction and its sources
//   exe_dest, exe_wb_en,
//   exe_mem_r_en                   ID/EX register destination info
//   mem_dest, mem_wb_en            EX/MEM register destination info
//   br_taken                       branch resolved taken in EXE
//   mem_req, sram_ready            MEM-stage SRAM handshake
//   freeze_if                      hold the PC and the IF/ID register
//   bubble_id                      zero the ID/EX control fields
//   flush_if                       clear the IF/ID register
//   freeze_pipe                    hold every pipeline register
//   mem_timeout                    sticky hung-memory flag (registered)
//   stall_cycles                   saturating stall counter (registered)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_if,
  output logic             bubble_id,
  output logic             flush_if,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WCNT_W   = (WCNT_RAW < 1) ? 1 : WCNT_RAW;
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [WCNT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic [CNT_W-1:0]    stall_cycles_r;
  logic                mem_timeout_r;
  logic                mem_stall_s;
  logic                freeze_raw_s;
  logic                hz_s;
  logic                stall_inc_s;

  // A source register collides with an in-flight writer. Register 0 is
  // hard-wired, so it never creates a dependency.
  function automatic logic src_hit(
    input logic [4:0] r,
    input logic [4:0] e_dest,
    input logic       e_wb,
    input logic       e_load,
    input logic [4:0] m_dest,
    input logic       m_wb
  );
    logic hit;
    hit = 1'b0;
    if (r != 5'd0) begin
`ifdef FORWARDING_EN
      // Forwarding covers everything except a load whose data is not yet read.
      hit = e_wb && e_load && (r == e_dest);
`else
      hit = (e_wb && (r == e_dest)) || (m_wb && (r == m_dest));
`endif
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Hazard detection: src1 is always read, src2 only for two-source ops.
  always_comb begin
    hz_s = 1'b0;
    if (id_valid) begin
      hz_s = src_hit(src1, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en) ||
             (two_src &&
              src_hit(src2, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en));
    end else begin
      hz_s = 1'b0;
    end
  end

  // Memory-wait FSM next state, wait counter and raw freeze request.
  always_comb begin
    state_s      = state_r;
    wait_cnt_s   = wait_cnt_r;
    mem_stall_s  = mem_req && !sram_ready;
    freeze_raw_s = 1'b0;
    case (state_r)
      RUN: begin
        freeze_raw_s = mem_stall_s;
        if (mem_stall_s) begin
          state_s    = MEM_WAIT;
          wait_cnt_s = WCNT_W'(1);
        end else begin
          state_s    = RUN;
        end
      end
      MEM_WAIT: begin
        freeze_raw_s = mem_stall_s;
        if (sram_ready) begin
          // Ready releases the freeze in this very cycle.
          state_s    = RUN;
          wait_cnt_s = '0;
        end else if (wait_cnt_r == TIMEOUT_V) begin
          state_s    = ERR;
        end else begin
          wait_cnt_s = wait_cnt_r + WCNT_W'(1);
        end
      end
      ERR: begin
        // Only reset leaves ERR.
        freeze_raw_s = 1'b1;
        state_s      = ERR;
      end
      default: begin
        state_s      = RUN;
        wait_cnt_s   = '0;
        freeze_raw_s = 1'b0;
      end
    endcase
  end

  // Output priority: memory freeze > branch flush > data hazard; all quiet in reset.
  always_comb begin
    freeze_pipe = 1'b0;
    freeze_if   = 1'b0;
    bubble_id   = 1'b0;
    flush_if    = 1'b0;
    if (rst) begin
      freeze_pipe = 1'b0;
    end else if (freeze_raw_s) begin
      freeze_pipe = 1'b1;
    end else if (br_taken) begin
      flush_if    = 1'b1;
      bubble_id   = 1'b1;
    end else if (hz_s) begin
      freeze_if   = 1'b1;
      bubble_id   = 1'b1;
    end else begin
      freeze_pipe = 1'b0;
    end
    // A branch bubble is a squash, not a stall, so it is not counted.
    stall_inc_s = freeze_pipe || (bubble_id && !flush_if);
  end

  // State, wait counter, stall counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= RUN;
      wait_cnt_r     <= '0;
      stall_cycles_r <= '0;
      mem_timeout_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      wait_cnt_r    <= wait_cnt_s;
      mem_timeout_r <= (state_s == ERR);
      if (stall_inc_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign mem_timeout  = mem_timeout_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15; the number of MEM_WAIT cycles after which a memory access is declared hung.
REQ-002 SHALL have parameter CNT_W, default 16; the width of the stall-cycle counter.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port id_valid  in  1  the ID stage holds a real instruction.
REQ-006 SHALL have ports src1, src2  in  5 each  ID source register numbers.
REQ-007 SHALL have port two_src  in  1  the ID instruction reads src2.
REQ-008 SHALL have ports exe_dest  in  5, exe_wb_en  in  1 and exe_mem_r_en  in  1  destination, writeback enable and load flag of the ID/EX register output.
REQ-009 SHALL have ports mem_dest  in  5 and mem_wb_en  in  1  destination and writeback enable of the EX/MEM register output.
REQ-010 SHALL have port br_taken  in  1  the branch resolved in EXE is taken.
REQ-011 SHALL have ports mem_req  in  1 and sram_ready  in  1  the MEM stage is accessing SRAM, and SRAM has completed the access.
REQ-012 SHALL have port freeze_if  out  1  hold the PC and the IF/ID register.
REQ-013 SHALL have port bubble_id  out  1  load zeros into the ID/EX control fields (WB_EN, MEM_R_EN, MEM_W_EN, Br_type, EXE_CMD).
REQ-014 SHALL have port flush_if  out  1  clear the IF/ID register.
REQ-015 SHALL have port freeze_pipe  out  1  hold every pipeline register.
REQ-016 SHALL have port mem_timeout  out  1  sticky hung-memory error flag.
REQ-017 SHALL have port stall_cycles  out  CNT_W  count of stall cycles.

Function
REQ-018 SHALL treat a register number of 0 as never matching any hazard.
REQ-019 SHALL define a data hazard (hz) as: id_valid=1 and the ID instruction reads a source register that matches exe_dest while exe_wb_en=1 and exe_mem_r_en=1 (load-use case); REQ-033 extends this definition.
REQ-020 SHALL define the ID instruction as reading src1 always, and src2 only when two_src=1.
REQ-021 SHALL implement an FSM with states RUN, MEM_WAIT and ERR, and a wait counter wait_cnt.
REQ-022 SHALL assert freeze_pipe combinationally when mem_req=1 and sram_ready=0 in RUN or MEM_WAIT, and always in ERR.
REQ-023 SHALL transition RUN to MEM_WAIT when mem_req=1 and sram_ready=0, setting wait_cnt to 1.
REQ-024 SHALL transition MEM_WAIT to RUN when sram_ready=1, with freeze_pipe deasserting in that same cycle.
REQ-025 SHALL increment wait_cnt each MEM_WAIT cycle in which sram_ready=0.
REQ-026 SHALL transition MEM_WAIT to ERR when wait_cnt=MEM_TIMEOUT and sram_ready=0.
REQ-027 SHALL hold ERR until reset, with mem_timeout=1 while in ERR.
REQ-028 SHALL apply output priority freeze_pipe > branch flush > data hazard: while freeze_pipe=1, the outputs freeze_if, bubble_id and flush_if SHALL all be 0.
REQ-029 SHALL, when br_taken=1 and freeze_pipe=0, assert flush_if=1 and bubble_id=1 in the same cycle, with freeze_if=0 and any hazard ignored.
REQ-030 SHALL, when hz=1, br_taken=0 and freeze_pipe=0, assert freeze_if=1 and bubble_id=1 for exactly that cycle, giving a one-cycle load-use stall.
REQ-031 SHALL increment stall_cycles on each clock where freeze_pipe=1 or (bubble_id=1 and flush_if=0), saturating at all-ones.
REQ-032 SHALL drive all outputs other than stall_cycles and mem_timeout combinationally from the current inputs and state, with zero added latency.

Reset
REQ-033 SHALL, with FORWARDING_EN undefined, extend hz to also include a match against exe_dest when exe_wb_en=1 (any instruction type), or against mem_dest when mem_wb_en=1.
REQ-034 SHALL, when rst=1 at a rising clk edge, set state=RUN, wait_cnt=0, stall_cycles=0 and mem_timeout=0.
REQ-035 SHALL, while rst=1, hold freeze_if, bubble_id, flush_if and freeze_pipe at 0.
REQ-036 SHALL, when reset occurs in MEM_WAIT or ERR, abandon the access, with no freeze in the following cycle unless mem_req=1 and sram_ready=0.

Configuration
REQ-037 SHALL, with macro FORWARDING_EN defined, assume a forwarding unit is present and restrict hz to the load-use case of REQ-019.
REQ-038 SHALL, with FORWARDING_EN undefined, apply the extended hz of REQ-033, for a design with no forwarding.

Verification
REQ-039 SHALL cover load-use: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1=5, id_valid=1 -> freeze_if=1, bubble_id=1 for one cycle, and stall_cycles +1.
REQ-040 SHALL cover register zero: same as REQ-039 but exe_dest=0 and src1=0 -> no stall.
REQ-041 SHALL cover branch plus hazard: br_taken=1 together with the load-use condition -> flush_if=1, bubble_id=1, freeze_if=0, and stall_cycles unchanged.
REQ-042 SHALL cover a memory wait: mem_req=1, sram_ready=0 for 4 cycles, then 1 -> freeze_pipe high for 4 cycles, low in the ready cycle, and stall_cycles +4.
REQ-043 SHALL cover timeout: mem_req=1, sram_ready=0 held for 20 cycles with MEM_TIMEOUT=15 -> ERR reached, mem_timeout=1 and freeze_pipe=1 sticky; rst=1 -> all cleared.
REQ-044 SHALL cover forwarding off: FORWARDING_EN undefined, mem_wb_en=1, mem_dest=7, two_src=1, src2=7 -> one-cycle stall; with FORWARDING_EN defined -> no stall.
